// File: rtl/uart_frame_rx_pkg.sv
// Shared state encoding and constants for the UART frame assembler.
package uart_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_HOLD    = 2'd3
    } frame_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_frame_rx_sync_pulse.sv
// Brings a divided-clock strobe into the system clock domain and emits a
// one-cycle pulse on its rising edge.
module uart_frame_rx_sync_pulse (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe_i,
    output logic pulse_o
);

    // [0] and [1] form the synchroniser, [2] holds the previous synced value
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], strobe_i};
        end
    end

    assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/uart_frame_rx.sv
// Collects received UART bytes into SYNC + payload + XOR-checksum frames and
// hands the checked payload out over valid/ready.
//   state   | meaning
//   IDLE    | waiting for SYNC_BYTE, other bytes ignored
//   PAYLOAD | shifting in payload bytes
//   CHECK   | waiting for the checksum byte
//   HOLD    | data_o valid, waiting for data_ready
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int         DATA_BYTES  = 2,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_done,
    output logic [8*DATA_BYTES-1:0] data_o,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic                    chk_err,
    output logic                    ovr_err,
    output logic                    tmo_err,
    output logic                    busy
);

    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int CNT_W  = $clog2(DATA_BYTES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    frame_state_e      state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        chk_q;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              valid_q;
    logic              chk_err_q;
    logic              ovr_err_q;
    logic              tmo_err_q;
    logic              byte_evt;
    logic              in_frame;
    logic              tmo_hit;

    uart_frame_rx_sync_pulse u_sync_done (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe_i (rx_done),
        .pulse_o  (byte_evt)
    );

    assign in_frame = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign tmo_hit  = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) && !byte_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            data_q     <= '0;
            chk_q      <= '0;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            valid_q    <= 1'b0;
            chk_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            chk_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
            tmo_err_q <= 1'b0;

            if (byte_evt) begin
                tmo_cnt_q <= '0;
            end else if (in_frame && tmo_cnt_q != TMO_W'(TIMEOUT_CYC)) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (byte_evt && rx_byte == SYNC_BYTE) begin
                        state_q    <= ST_PAYLOAD;
                        byte_cnt_q <= '0;
                        chk_q      <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_evt) begin
                        shreg_q    <= (shreg_q << 8) | DATA_W'(rx_byte);
                        chk_q      <= chk_q ^ rx_byte;
                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        if (byte_cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                            state_q <= ST_CHECK;
                        end
                    end else if (tmo_hit) begin
                        tmo_err_q <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (byte_evt) begin
                        if (rx_byte == chk_q) begin
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                            state_q <= ST_HOLD;
                        end else begin
                            chk_err_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        tmo_err_q <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // a byte coinciding with the handshake is treated as if already in IDLE
                    if (data_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                        if (byte_evt && rx_byte == SYNC_BYTE) begin
                            state_q    <= ST_PAYLOAD;
                            byte_cnt_q <= '0;
                            chk_q      <= '0;
                        end
                    end else if (byte_evt) begin
                        ovr_err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_o     = data_q;
    assign data_valid = valid_q;
    assign chk_err    = chk_err_q;
    assign ovr_err    = ovr_err_q;
    assign tmo_err    = tmo_err_q;
    assign busy       = in_frame;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: frame table plus hand-written
// backpressure, timeout and reset sequences, with a word scoreboard.
module tb_uart_frame_rx;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_done = 1'b0;
    logic        data_ready = 1'b1;
    logic [15:0] data_o;
    logic        data_valid;
    logic        chk_err;
    logic        ovr_err;
    logic        tmo_err;
    logic        busy;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .DATA_BYTES  (2),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .data_o     (data_o),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .chk_err    (chk_err),
        .ovr_err    (ovr_err),
        .tmo_err    (tmo_err),
        .busy       (busy)
    );

    int total = 0;
    int bad = 0;
    int n_chk = 0;
    int n_ovr = 0;
    int n_tmo = 0;
    int n_valid = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        int          n;
        logic [63:0] b;
        logic        has_word;
        logic [15:0] word;
        int          nchk;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_chk = 0;
        n_ovr = 0;
        n_tmo = 0;
        n_valid = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b;
        rx_done = 1'b1;
        repeat (4) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (chk_err) n_chk++;
            if (ovr_err) n_ovr++;
            if (tmo_err) n_tmo++;
            if (data_valid) n_valid++;
            if (data_valid && data_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got %h want no word", data_o);
                end else begin
                    check("sb_word", data_o, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] last_word;
        vec_t        v;
        int          k;
        last_word = 16'h0000;

        vecs[0] = '{4, 64'hA512_3426_0000_0000, 1'b1, 16'h1234, 0};
        vecs[1] = '{4, 64'hA512_3400_0000_0000, 1'b0, 16'h0000, 1};
        vecs[2] = '{4, 64'hA5AB_CD66_0000_0000, 1'b1, 16'hABCD, 0};
        vecs[3] = '{6, 64'h00FF_A5A5_01A4_0000, 1'b1, 16'hA501, 0};
        vecs[4] = '{4, 64'hA500_0000_0000_0000, 1'b1, 16'h0000, 0};
        vecs[5] = '{4, 64'hA5FF_FF00_0000_0000, 1'b1, 16'hFFFF, 0};
        vecs[6] = '{5, 64'h33A5_5A5A_0000_0000, 1'b1, 16'h5A5A, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", data_o, 16'h0000);
        check("rst_valid", data_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {chk_err, ovr_err, tmo_err}, 3'b000);
        @(posedge clk); #1 reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            clr_counts();
            if (v.has_word) sb_q.push_back(v.word);
            for (int j = 0; j < v.n; j++) send_byte(v.b[63-8*j -: 8]);
            settle();
            if (v.has_word) last_word = v.word;
            check($sformatf("v%0d_chk", i), n_chk, v.nchk);
            check($sformatf("v%0d_ovr_tmo", i), n_ovr + n_tmo, 0);
            check($sformatf("v%0d_valid_cyc", i), n_valid, v.has_word ? 1 : 0);
            check($sformatf("v%0d_data", i), data_o, last_word);
            check($sformatf("v%0d_busy", i), busy, 1'b0);
            check($sformatf("v%0d_sb", i), sb_q.size(), 0);
        end

        // backpressure: word held while further bytes are dropped
        clr_counts();
        data_ready = 1'b0;
        sb_q.push_back(16'h1234);
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
        settle();
        check("bp_valid", data_valid, 1'b1);
        check("bp_data", data_o, 16'h1234);
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
        settle();
        check("bp_ovr", n_ovr, 3);
        check("bp_data_stable", data_o, 16'h1234);
        check("bp_valid_held", data_valid, 1'b1);
        check("bp_busy", busy, 1'b0);
        @(posedge clk); #1 data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_drop", data_valid, 1'b0);
        check("bp_sb", sb_q.size(), 0);
        check("bp_other_err", n_chk + n_tmo, 0);
        last_word = 16'h1234;

        // timeout after a partial frame, then recovery
        clr_counts();
        send_byte(8'hA5); send_byte(8'h12);
        @(negedge clk);
        check("to_busy_pre", busy, 1'b1);
        k = 0;
        while (n_tmo == 0 && k < TMO + 20) begin
            @(negedge clk);
            k++;
        end
        check("to_pulse", n_tmo, 1);
        check("to_busy", busy, 1'b0);
        sb_q.push_back(16'h1234);
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
        settle();
        check("to_recover_sb", sb_q.size(), 0);
        check("to_recover_tmo", n_tmo, 1);

        // byte event lands exactly on the expiry cycle: no timeout
        clr_counts();
        sb_q.push_back(16'h1234);
        @(posedge clk); #1;
        rx_byte = 8'hA5; rx_done = 1'b1;
        repeat (4) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (TMO - 4) @(posedge clk);
        #1 rx_byte = 8'h12; rx_done = 1'b1;
        repeat (4) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (3) @(posedge clk);
        send_byte(8'h34); send_byte(8'h26);
        settle();
        check("edge_tmo", n_tmo, 0);
        check("edge_sb", sb_q.size(), 0);

        // one cycle later: timeout fires and the late bytes are ignored
        clr_counts();
        @(posedge clk); #1;
        rx_byte = 8'hA5; rx_done = 1'b1;
        repeat (4) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (TMO - 3) @(posedge clk);
        #1 rx_byte = 8'h12; rx_done = 1'b1;
        repeat (4) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (3) @(posedge clk);
        send_byte(8'h34); send_byte(8'h26);
        settle();
        check("late_tmo", n_tmo, 1);
        check("late_valid_cyc", n_valid, 0);
        check("late_busy", busy, 1'b0);
        check("late_data", data_o, last_word);

        // asynchronous reset in the middle of a frame
        send_byte(8'hA5); send_byte(8'h12);
        @(negedge clk);
        check("mr_busy_pre", busy, 1'b1);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        check("mr_busy", busy, 1'b0);
        check("mr_data", data_o, 16'h0000);
        check("mr_valid", data_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clr_counts();
        sb_q.push_back(16'h5678);
        send_byte(8'hA5); send_byte(8'h56); send_byte(8'h78); send_byte(8'h2E);
        settle();
        check("mr_sb", sb_q.size(), 0);
        check("mr_data_new", data_o, 16'h5678);
        check("mr_errs", n_chk + n_ovr + n_tmo, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
